// File: rtl/mmio_finisher.sv
// mmio_finisher: MMIO simulation-finish responder with scratch register and drain delay.
// Optional watchdog timeout enabled by defining FINISHER_WATCHDOG_EN.
module mmio_finisher #(
    parameter logic [31:0] BASE_ADDR      = 32'h0010_0000,
    parameter logic [31:0] LAST_ADDR      = 32'h0010_0007,
    parameter int unsigned DRAIN_CYCLES   = 8,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_error,
    output logic [31:0] resp_rdata,
    output logic        finish_valid,
    output logic        finish_pass,
    output logic [15:0] finish_code
);
    typedef enum logic [1:0] {IDLE, RESP, DRAIN, DONE} state_t;

    localparam logic [31:0] DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 32'd0 : DRAIN_CYCLES - 1;

    state_t      r_state;
    logic [31:0] r_drain;
    logic [31:0] r_scratch;
    logic        r_fin_pend;
    logic        r_resp_valid;
    logic        r_resp_error;
    logic [31:0] r_resp_rdata;
    logic        r_fin_valid;
    logic        r_pass;
    logic [15:0] r_code;

    logic [31:0] w_off;
    logic        w_ok;
    logic        w_fin;
    logic        w_timeout;

    assign w_off = req_addr - BASE_ADDR;
    assign w_ok  = (req_addr >= BASE_ADDR) && (req_addr <= LAST_ADDR) && (req_addr[1:0] == 2'b00);
    assign w_fin = w_ok && req_wen && (w_off == 32'd0) &&
                   ((req_wdata[15:0] == 16'h5555) || (req_wdata[15:0] == 16'h3333));

`ifdef FINISHER_WATCHDOG_EN
    logic [31:0] r_wd;
    assign w_timeout = r_wd >= TIMEOUT_CYCLES - 32'd1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_wd <= 32'd0;
        else if (r_state == IDLE || r_state == RESP)
            r_wd <= r_wd + 32'd1;
    end
`else
    logic w_unused;
    assign w_unused  = ^TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_drain      <= 32'd0;
            r_scratch    <= 32'd0;
            r_fin_pend   <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_fin_valid  <= 1'b0;
            r_pass       <= 1'b0;
            r_code       <= 16'd0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_rdata <= 32'd0;
            case (r_state)
                IDLE: begin
                    // A handshake wins over a watchdog expiry in the same cycle
                    if (req_valid) begin
                        r_state      <= RESP;
                        r_resp_valid <= 1'b1;
                        r_resp_error <= !w_ok;
                        r_resp_rdata <= (w_ok && !req_wen && w_off == 32'd4) ? r_scratch : 32'd0;
                        r_fin_pend   <= w_fin;
                        if (w_ok && req_wen && w_off == 32'd4)
                            r_scratch <= req_wdata;
                        if (w_fin) begin
                            r_pass <= req_wdata[15:0] == 16'h5555;
                            r_code <= req_wdata[31:16];
                        end
                    end else if (w_timeout) begin
                        r_state     <= DONE;
                        r_fin_valid <= 1'b1;
                        r_pass      <= 1'b0;
                        r_code      <= 16'hFFFF;
                    end
                end
                RESP: begin
                    r_state <= r_fin_pend ? DRAIN : IDLE;
                    r_drain <= DRAIN_LOAD;
                end
                DRAIN: begin
                    if (r_drain == 32'd0) begin
                        r_state     <= DONE;
                        r_fin_valid <= 1'b1;
                    end else begin
                        r_drain <= r_drain - 32'd1;
                    end
                end
                DONE: r_state <= DONE;
            endcase
        end
    end

    assign req_ready    = (r_state == IDLE) && !reset;
    assign resp_valid   = r_resp_valid;
    assign resp_error   = r_resp_error;
    assign resp_rdata   = r_resp_rdata;
    assign finish_valid = r_fin_valid;
    assign finish_pass  = r_pass;
    assign finish_code  = r_code;
endmodule

// File: tb/tb_mmio_finisher.sv
// tb_mmio_finisher: scoreboard bench for mmio_finisher responses and finish sequencing.
module tb_mmio_finisher;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        req_wen = 1'b0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_error;
    logic [31:0] resp_rdata;
    logic        finish_valid;
    logic        finish_pass;
    logic [15:0] finish_code;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;
    exp_t q[$];

    mmio_finisher #(
        .BASE_ADDR(32'h0010_0000),
        .LAST_ADDR(32'h0010_0007),
        .DRAIN_CYCLES(8),
        .TIMEOUT_CYCLES(32'd100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr(req_addr),
        .req_wen(req_wen),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_error(resp_error),
        .resp_rdata(resp_rdata),
        .finish_valid(finish_valid),
        .finish_pass(finish_pass),
        .finish_code(finish_code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("resp_error", {31'd0, resp_error}, {31'd0, e.err});
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                          input logic err, input logic [31:0] rdata, output int h);
        int n = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) chk("ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_addr  = addr;
        req_wen   = wen;
        req_wdata = wdata;
        @(posedge clk);
        #1;
        h = cyc;
        q.push_back('{err: err, rdata: rdata, cyc: cyc});
        req_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic fin_check(input int h, input logic pass, input logic [15:0] code);
        wait_cyc(h + 8);
        chk("finish_early", {31'd0, finish_valid}, 32'd0);
        @(negedge clk);
        chk("finish_valid", {31'd0, finish_valid}, 32'd1);
        chk("finish_pass", {31'd0, finish_pass}, {31'd0, pass});
        chk("finish_code", {16'd0, finish_code}, {16'd0, code});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_fin_valid", {31'd0, finish_valid}, 32'd0);
        chk("rst_fin_pass", {31'd0, finish_pass}, 32'd0);
        chk("rst_fin_code", {16'd0, finish_code}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int h;
        #12;
        chk("init_ready", {31'd0, req_ready}, 32'd0);
        chk("init_resp_error", {31'd0, resp_error}, 32'd0);
        chk("init_resp_rdata", resp_rdata, 32'd0);
        do_reset();

        do_req(32'h0010_0004, 1'b0, 32'd0, 1'b0, 32'd0, h);
        do_req(32'h0010_0004, 1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0, h);
        do_req(32'h0010_0004, 1'b0, 32'd0, 1'b0, 32'hDEAD_BEEF, h);
        do_req(32'h0010_0002, 1'b0, 32'd0, 1'b1, 32'd0, h);
        do_req(32'h0010_0008, 1'b0, 32'd0, 1'b1, 32'd0, h);
        do_req(32'h0010_0008, 1'b1, 32'h1111_1111, 1'b1, 32'd0, h);
        do_req(32'h000F_FFFC, 1'b1, 32'h2222_2222, 1'b1, 32'd0, h);
        do_req(32'h0010_0006, 1'b1, 32'h0000_5555, 1'b1, 32'd0, h);
        do_req(32'h0010_0004, 1'b0, 32'd0, 1'b0, 32'hDEAD_BEEF, h);
        do_req(32'h0010_0000, 1'b0, 32'd0, 1'b0, 32'd0, h);

        do_req(32'h0010_0000, 1'b1, 32'h0000_1234, 1'b0, 32'd0, h);
        @(negedge clk);
        chk("ready_in_resp", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_resp", {31'd0, req_ready}, 32'd1);
        wait_cyc(h + 12);
        chk("no_finish_1234", {31'd0, finish_valid}, 32'd0);

        do_req(32'h0010_0000, 1'b1, 32'h0007_3333, 1'b0, 32'd0, h);
        wait_cyc(h + 4);
        do_reset();
        wait_cyc(cyc + 15);
        chk("fin_after_rst", {31'd0, finish_valid}, 32'd0);
        chk("q_empty_rst", q.size(), 32'd0);
        do_req(32'h0010_0004, 1'b0, 32'd0, 1'b0, 32'd0, h);

        do_req(32'h0010_0000, 1'b1, 32'h002A_5555, 1'b0, 32'd0, h);
        wait_cyc(h + 3);
        req_valid = 1'b1;
        req_addr  = 32'h0010_0004;
        req_wen   = 1'b0;
        #1;
        chk("ready_in_drain", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        fin_check(h, 1'b1, 16'h002A);
        wait_cyc(cyc + 5);
        chk("fin_sticky", {31'd0, finish_valid}, 32'd1);
        chk("ready_in_done", {31'd0, req_ready}, 32'd0);

        do_reset();
        do_req(32'h0010_0000, 1'b1, 32'h0011_3333, 1'b0, 32'd0, h);
        fin_check(h, 1'b0, 16'h0011);

        do_reset();
        h = cyc;
`ifdef FINISHER_WATCHDOG_EN
        wait_cyc(h + 99);
        chk("wd_early", {31'd0, finish_valid}, 32'd0);
        @(negedge clk);
        chk("wd_valid", {31'd0, finish_valid}, 32'd1);
        chk("wd_pass", {31'd0, finish_pass}, 32'd0);
        chk("wd_code", {16'd0, finish_code}, 32'h0000_FFFF);
`else
        wait_cyc(h + 150);
        chk("no_wd_finish", {31'd0, finish_valid}, 32'd0);
`endif
        chk("q_empty_end", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mmio_finisher.md
MMIO_FINISHER -- requirements
Module: mmio_finisher

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0010_0000, meaning first byte address decoded.
REQ-002 SHALL have parameter LAST_ADDR, default 32'h0010_0007, meaning last byte address decoded (inclusive).
REQ-003 SHALL have parameter DRAIN_CYCLES, default 8, meaning cycles between accepted finish write and finish_valid.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 32'd1_000_000, meaning watchdog limit (used only under REQ-030).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 req_valid  in  1  request present.
REQ-008 req_ready  out  1  responder can accept request.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wen  in  1  1 = write, 0 = read.
REQ-011 req_wdata  in  32  write data.
REQ-012 resp_valid  out  1  one-cycle response pulse.
REQ-013 resp_error  out  1  access fault, qualified by resp_valid.
REQ-014 resp_rdata  out  32  read data, qualified by resp_valid.
REQ-015 finish_valid  out  1  simulation termination request, sticky.
REQ-016 finish_pass  out  1  1 = pass, 0 = fail, qualified by finish_valid.
REQ-017 finish_code  out  16  exit code, qualified by finish_valid.

Function
REQ-018 States SHALL be IDLE, RESP, DRAIN, DONE.
- IDLE: req_ready=1; handshake = req_valid & req_ready → latch request, go RESP.
- RESP: req_ready=0; resp_valid=1 for exactly one cycle; next IDLE, or DRAIN if a finish command was latched.
- DRAIN: counter loads DRAIN_CYCLES-1, decrements each cycle; at 0 go DONE. DRAIN_CYCLES=0 SHALL be treated as 1.
- DONE: terminal until reset.
REQ-019 Latency SHALL be fixed: response one cycle after handshake; one request in flight at most.
REQ-020 Decode: in range iff BASE_ADDR <= req_addr <= LAST_ADDR (unsigned); aligned iff req_addr[1:0]==0.
REQ-021 Out-of-range or misaligned request SHALL give resp_error=1, resp_rdata=0, no side effect.
REQ-022 Write to offset 0 with wdata[15:0]==16'h5555 SHALL be finish-pass, code wdata[31:16].
REQ-023 Write to offset 0 with wdata[15:0]==16'h3333 SHALL be finish-fail, code wdata[31:16].
REQ-024 Any other write to offset 0 SHALL complete without error and without effect.
REQ-025 Offset 4 SHALL be a 32-bit scratch register: writable, readable, reset 0; read of offset 0 SHALL return 0.
REQ-026 finish_pass/finish_code SHALL be captured at the handshake and held; finish_valid SHALL rise on entry to DONE and stay 1.
REQ-027 In DRAIN and DONE, req_ready SHALL stay 0; incoming requests SHALL be ignored.

Reset
REQ-028 reset SHALL asynchronously force IDLE, drain counter 0, scratch 0; outputs req_ready=0 while reset is asserted, then 1 in IDLE; resp_valid=0, resp_error=0, resp_rdata=0, finish_valid=0, finish_pass=0, finish_code=0.
REQ-029 Reset asserted in RESP or DRAIN SHALL drop the pending response and the pending finish; no output pulses after deassertion.

Configuration
REQ-030 Macro FINISHER_WATCHDOG_EN SHALL enable a 32-bit cycle counter that clears on reset and increments each cycle outside DRAIN/DONE; on reaching TIMEOUT_CYCLES it SHALL jump directly to DONE with finish_pass=0, finish_code=16'hFFFF. A handshake in the same cycle SHALL take priority over the timeout.
REQ-031 Without FINISHER_WATCHDOG_EN, no counter SHALL exist and TIMEOUT_CYCLES SHALL be unused.

Verification
REQ-032 Write 0x0010_0000 ← 0x002A_5555, DRAIN_CYCLES=8 → resp_valid next cycle, error 0; finish_valid=1 at handshake+1+8, pass=1, code=0x002A.
REQ-033 Write 0x0010_0004 ← 0xDEAD_BEEF, then read 0x0010_0004 → read resp_rdata=0xDEADBEEF, error 0.
REQ-034 Read 0x0010_0002 and read 0x0010_0008 → each resp_error=1, rdata=0; state unchanged.
REQ-035 Write 0x0010_0000 ← 0x0007_3333, assert reset mid-DRAIN → finish_valid stays 0; new pass write then finishes with code per REQ-032.
REQ-036 With FINISHER_WATCHDOG_EN, TIMEOUT_CYCLES=100, no requests → finish_valid=1, pass=0, code=0xFFFF after 100 cycles; without macro → finish_valid stays 0.
REQ-037 Write 0x0010_0000 ← 0x0000_1234 → resp error 0, no finish; req_ready=1 again the following cycle.
